cart_mem_fetch: RTL
===================

// Module: cart_mem_fetch
// PURPOSE
// Downstream of the cartridge mapper stage. Takes the mapped ROM address and cart-RAM address,
// runs the request/ack transaction on the shared 16-bit cart memory port, and returns read data.
// - ROM data goes to the CPU data mux; cart-RAM data goes to the mapper's cram_di input.
// - Holds a one-word ROM read buffer and asserts cpu_wait while a transaction is outstanding.
// PARAMETERS
// ROM_AW    23        mapped ROM byte-address width (mbc_addr)
// RAM_AW    17        cart-RAM byte-address width (cram_addr)
// MEM_AW    24        memory-port byte-address width
// RAM_BASE  24'h800000  byte offset of cart RAM on the memory port
// PORTS
// clk_sys      in   1        system clock
// reset        in   1        asynchronous, active-high reset
// ce_cpu       in   1        CPU bus-cycle strobe
// cart_rd      in   1        CPU read, sampled on ce_cpu
// cart_wr      in   1        CPU write, sampled on ce_cpu
// cart_a15     in   1        CPU A15
// cart_addr    in   15       CPU A14..A0
// cart_di      in   8        CPU write data
// mbc_addr     in   ROM_AW   mapped ROM address from mapper
// cram_addr    in   RAM_AW   mapped cart-RAM address from mapper
// ram_enabled  in   1        cart-RAM enable from mapper
// rom_do       out  8        ROM read byte
// cram_di      out  8        cart-RAM read byte (to mapper)
// cpu_wait     out  1        transaction outstanding; upstream gates ce_cpu
// overrun      out  1        sticky: strobe dropped while busy with pending full
// mem_req      out  1        memory request, level; held until mem_ack
// mem_we       out  1        write qualifier, valid with mem_req
// mem_addr     out  MEM_AW   byte address; bit0 selects byte lane
// mem_wdata    out  8        write byte
// mem_ack      in   1        one-cycle completion pulse
// mem_rdata    in   16       read word; valid on mem_ack
// BEHAVIOUR
// - Reset values: all outputs 0 except rom_do=cram_di=8'hFF; buffer invalid; FSM IDLE.
// - Decode at strobe (ce_cpu & (cart_rd|cart_wr)):
//   - ROM = ~cart_a15;
//   - RAM = cart_a15 & cart_addr[14:13]==2'b01 & ram_enabled.
//   - Any other access: no memory transaction.
// - ROM reads, buffer hit (valid & tag==mbc_addr[ROM_AW-1:1]): rom_do updates next cycle; no mem_req.
// - ROM reads, miss: FSM IDLE->ROM_RD.
//   - mem_addr={0,mbc_addr}, mem_req=1 the cycle after the strobe.
//   - On mem_ack: store word and tag, valid=1; rom_do = mbc_addr[0] ? rdata[15:8] : rdata[7:0].
// - RAM read: IDLE->RAM_RD, mem_addr=RAM_BASE+cram_addr. On ack, cram_di gets the lane byte.
// - RAM write: IDLE->RAM_WR, mem_we=1, mem_wdata=cart_di. ROM writes never reach memory (mapper registers).
// - Disabled-RAM access: cram_di=8'hFF for reads; writes are dropped.
// - mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the ack cycle.
// - mem_req deasserts in the ack cycle's next edge; FSM then returns to IDLE.
// - Next transaction may start the cycle after returning to IDLE (min 1 idle cycle between reqs).
// - cpu_wait=1 from the cycle after a miss/RAM strobe through the ack cycle inclusive.
// - Strobe while busy:
//   - latched into a single pending slot (type, addresses, data); served after IDLE return.
//   - strobe while pending full: dropped, overrun set (cleared only by reset).
// - mem_ack while IDLE: ignored.
// - Reset mid-transaction: mem_req drops immediately (async); pending and buffer cleared.
// - Address widths: mbc_addr and cram_addr zero-extended to MEM_AW before the RAM_BASE add.
//   - RAM_BASE+cram_addr must not carry out of MEM_AW.
// STRUCTURE
// - Shared package gb_cart_pkg: FSM state enum (IDLE, ROM_RD, RAM_RD, RAM_WR), access-type
//   enum (ACC_NONE, ACC_ROM, ACC_RAM_RD, ACC_RAM_WR), RAM_BASE constant.
// - One sub-module: cart_rom_wordbuf (tag, valid, 16-bit word, lane select, invalidate on reset).
// - FSM, decode and pending slot stay in the top module.
// TESTING
// 1. ROM read mbc_addr=23'h004001, ack rdata=16'hBEEF after 3 cycles:
//    -> mem_addr=24'h004001, rom_do=8'hBE, cpu_wait high 4 cycles.
// 2. Follow-up read 23'h004000 -> no mem_req; rom_do=8'hEF next cycle (buffer hit).
// 3. RAM write ram_enabled=1, cart_a15=1, cart_addr=15'h2000, cram_addr=17'h00003, cart_di=8'h5A
//    -> mem_we=1, mem_addr=24'h800003, mem_wdata=8'h5A.
// 4. RAM read with ram_enabled=0 -> no mem_req, cram_di=8'hFF, cpu_wait stays 0.
// 5. Three strobes during one outstanding miss -> second served after first ack, overrun=1.
// 6. Assert reset while mem_req=1 -> mem_req=0 same cycle; prior-hit address re-read issues mem_req.

Source files
------------

// File: rtl/gb_cart_pkg.sv
// Shared types for the cartridge memory-fetch path: FSM states, access kinds
// and the default placement of cart RAM on the memory port.
package gb_cart_pkg;
    typedef enum logic [1:0] {IDLE, ROM_RD, RAM_RD, RAM_WR} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_ROM, ACC_RAM_RD, ACC_RAM_WR} acc_t;
    localparam logic [23:0] CART_RAM_BASE = 24'h800000;
endpackage

// File: rtl/cart_rom_wordbuf.sv
// One-word ROM read buffer: tag on the word address, byte lane picked by bit 0.
module cart_rom_wordbuf #(
    parameter int ROM_AW = 23
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              fill,
    input  logic [ROM_AW-1:0] fill_addr,
    input  logic [15:0]       fill_word,
    input  logic [ROM_AW-1:0] look_addr,
    output logic              hit,
    output logic [7:0]        look_byte
);
    logic              valid;
    logic [ROM_AW-2:0] tag;
    logic [15:0]       word;
    wire               unused_lane = fill_addr[0];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr[ROM_AW-1:1];
            word  <= fill_word;
        end
    end

    assign hit       = valid && (tag == look_addr[ROM_AW-1:1]);
    assign look_byte = look_addr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/cart_mem_fetch.sv
// Runs ROM / cart-RAM accesses from the mapper over the shared 16-bit memory
// port, with a one-word ROM buffer and a single pending slot for busy strobes.
module cart_mem_fetch
    import gb_cart_pkg::*;
#(
    parameter int ROM_AW = 23,
    parameter int RAM_AW = 17,
    parameter int MEM_AW = 24,
    parameter logic [MEM_AW-1:0] RAM_BASE = MEM_AW'(CART_RAM_BASE)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_cpu,
    input  logic              cart_rd,
    input  logic              cart_wr,
    input  logic              cart_a15,
    input  logic [14:0]       cart_addr,
    input  logic [7:0]        cart_di,
    input  logic [ROM_AW-1:0] mbc_addr,
    input  logic [RAM_AW-1:0] cram_addr,
    input  logic              ram_enabled,
    output logic [7:0]        rom_do,
    output logic [7:0]        cram_di,
    output logic              cpu_wait,
    output logic              overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);
    typedef struct packed {
        acc_t              acc;
        logic [ROM_AW-1:0] rom_addr;
        logic [RAM_AW-1:0] ram_addr;
        logic [7:0]        wdata;
    } req_t;

    state_t            state, state_nx;
    req_t              cur_req, pend, serve_req;
    logic              pend_vld, busy, strobe, ram_sel, dis_rd, serve;
    logic              buf_hit, fill;
    logic [7:0]        buf_byte;
    logic [ROM_AW-1:0] txn_rom_addr;
    wire               unused_addr = &{1'b0, cart_addr[12:0]};

    // Read wins if rd and wr are both set; ROM writes belong to the mapper only.
    always_comb begin
        strobe           = ce_cpu & (cart_rd | cart_wr);
        ram_sel          = cart_a15 & (cart_addr[14:13] == 2'b01);
        dis_rd           = strobe & ram_sel & ~ram_enabled & cart_rd;
        cur_req.acc      = ACC_NONE;
        cur_req.rom_addr = mbc_addr;
        cur_req.ram_addr = cram_addr;
        cur_req.wdata    = cart_di;
        if (strobe) begin
            if (!cart_a15) begin
                if (cart_rd) cur_req.acc = ACC_ROM;
            end else if (ram_sel && ram_enabled) begin
                cur_req.acc = cart_rd ? ACC_RAM_RD : ACC_RAM_WR;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign serve_req = pend_vld ? pend : cur_req;
    assign serve     = !busy && (serve_req.acc != ACC_NONE);
    assign fill      = (state == ROM_RD) && mem_ack;
    assign mem_req   = busy;
    assign mem_we    = (state == RAM_WR);
    assign cpu_wait  = busy | pend_vld;

    cart_rom_wordbuf #(.ROM_AW(ROM_AW)) u_wordbuf (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .fill      (fill),
        .fill_addr (txn_rom_addr),
        .fill_word (mem_rdata),
        .look_addr (serve_req.rom_addr),
        .hit       (buf_hit),
        .look_byte (buf_byte)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (serve) begin
                case (serve_req.acc)
                    ACC_ROM:    if (!buf_hit) state_nx = ROM_RD;
                    ACC_RAM_RD: state_nx = RAM_RD;
                    ACC_RAM_WR: state_nx = RAM_WR;
                    default:    state_nx = IDLE;
                endcase
            end
            default: if (mem_ack) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_vld     <= 1'b0;
            pend         <= '0;
            overrun      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            txn_rom_addr <= '0;
            rom_do       <= 8'hFF;
            cram_di      <= 8'hFF;
        end else begin
            if (serve && state_nx != IDLE) begin
                txn_rom_addr <= serve_req.rom_addr;
                mem_wdata    <= serve_req.wdata;
                mem_addr     <= (serve_req.acc == ACC_ROM) ? MEM_AW'(serve_req.rom_addr)
                                                           : RAM_BASE + MEM_AW'(serve_req.ram_addr);
            end
            // The slot drains whenever IDLE; a strobe in that same cycle refills it.
            if (!busy && pend_vld) begin
                pend_vld <= (cur_req.acc != ACC_NONE);
                pend     <= cur_req;
            end else if (busy && cur_req.acc != ACC_NONE) begin
                if (pend_vld) begin
                    overrun <= 1'b1;
                end else begin
                    pend     <= cur_req;
                    pend_vld <= 1'b1;
                end
            end
            if (serve && serve_req.acc == ACC_ROM && buf_hit)
                rom_do <= buf_byte;
            else if (fill)
                rom_do <= txn_rom_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
            if (state == RAM_RD && mem_ack)
                cram_di <= mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
            else if (dis_rd)
                cram_di <= 8'hFF;
        end
    end
endmodule
